// File: rtl/fsm_bit_serializer.sv
// fsm_bit_serializer
//   Turns parallel words into the serial bit stream that feeds the input A of
//   the downstream single-bit Mealy machine. Each bit is held for BIT_CYCLES
//   clocks. A one-entry hold register lets words stream back to back with no
//   gap. While idle the stream is driven to 0, which parks the downstream
//   machine in its reset state.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing to send; a_out=0, a_valid=0; next word loads directly
//   SHIFT | shifting out the word in shift_q; hold_q may hold the next one
//
// Ports
//   clk        rising-edge clock, shared with the downstream machine
//   rst_n      asynchronous active-low reset
//   din        parallel word to serialize
//   din_valid  din is valid
//   din_ready  a word can be accepted (hold register empty)
//   a_out      serial bit for the downstream A input
//   a_valid    a_out carries a data bit
//   a_last     high for every cycle of the final bit of a word
//   busy       high while shifting
module fsm_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a_out,
  output logic             a_valid,
  output logic             a_last,
  output logic             busy
);

  localparam int BW = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;

  logic             xfer;
  logic             div_term;
  logic             word_done;
  logic [WIDTH-1:0] shift_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;

    // din_ready is exactly !hold_full_q, so the hold can never be overwritten.
    xfer      = din_valid && !hold_full_q;
    div_term  = (div_cnt_q == DIV_LAST);
    word_done = div_term && (bit_cnt_q == BIT_LAST);

    if (MSB_FIRST) shift_adv = {shift_q[WIDTH-2:0], 1'b0};
    else           shift_adv = {1'b0, shift_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shift_d   = din;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (word_done) begin
          bit_cnt_d = '0;
          div_cnt_d = '0;
          // Held word first; otherwise a word arriving on this very edge
          // bypasses the hold so the stream stays contiguous.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            shift_d = din;
          end else begin
            shift_d = '0;
            state_d = IDLE;
          end
        end else begin
          if (div_term) begin
            shift_d   = shift_adv;
            bit_cnt_d = bit_cnt_q + 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
          if (xfer) begin
            hold_d      = din;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign busy      = (state_q == SHIFT);
  assign a_valid   = busy;
  assign a_out     = busy && (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign a_last    = busy && (bit_cnt_q == BIT_LAST);
  assign din_ready = !hold_full_q;

endmodule
